// File: rtl/nn_cfg_sequencer_pkg.sv
// nn_cfg_sequencer_pkg: default sizing, per-layer neuron counts and the sequencer FSM encoding.
// Layer sizes are packed with layer 0 (input) in the least-significant SIZE_W field.
package nn_cfg_sequencer_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_SIZE_W     = 16;
  localparam int unsigned DEFAULT_NUM_LAYERS = 4;

  localparam logic [15:0] numNeuronLayer0 = 16'd784;
  localparam logic [15:0] numNeuronLayer1 = 16'd30;
  localparam logic [15:0] numNeuronLayer2 = 16'd30;
  localparam logic [15:0] numNeuronLayer3 = 16'd30;
  localparam logic [15:0] numNeuronLayer4 = 16'd10;

  localparam logic [(DEFAULT_NUM_LAYERS+1)*DEFAULT_SIZE_W-1:0] DEFAULT_LAYER_SIZES =
    {numNeuronLayer4, numNeuronLayer3, numNeuronLayer2, numNeuronLayer1, numNeuronLayer0};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/nn_cfg_cksum.sv
// nn_cfg_cksum: mod-2^32 running sum of accepted config words, compared against the trailing word.
// Only instantiated when CFG_CHECKSUM_EN is defined.
module nn_cfg_cksum (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        acc_i,
  input  logic        check_i,
  input  logic [31:0] data_i,
  output logic        err_o
);

  logic [31:0] sum_q;
  logic        err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else if (clear_i) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (acc_i)                        sum_q <= sum_q + data_i;
      if (check_i && (data_i != sum_q)) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/nn_cfg_sequencer.sv
// nn_cfg_sequencer: walks layers 1..NUM_LAYERS / neurons over a flat cfg word stream and emits
// weight/bias strobes with target layer/neuron. Define CFG_CHECKSUM_EN for a trailing checksum word.
module nn_cfg_sequencer
  import nn_cfg_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned NUM_LAYERS = DEFAULT_NUM_LAYERS,
  parameter int unsigned SIZE_W     = DEFAULT_SIZE_W,
  parameter logic [(NUM_LAYERS+1)*SIZE_W-1:0] LAYER_SIZES = DEFAULT_LAYER_SIZES
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic [31:0]           config_layer_num,
  output logic [31:0]           config_neuron_num,
  output logic [DATA_WIDTH-1:0] weightValue,
  output logic                  weightValid,
  output logic [DATA_WIDTH-1:0] biasValue,
  output logic                  biasValid,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           words_loaded
`ifdef CFG_CHECKSUM_EN
  ,
  output logic                  cksum_err
`endif
);

  function automatic int unsigned max_layer_size();
    int unsigned m = 2;
    for (int unsigned i = 0; i <= NUM_LAYERS; i++)
      if (32'(LAYER_SIZES[i*SIZE_W +: SIZE_W]) > m) m = 32'(LAYER_SIZES[i*SIZE_W +: SIZE_W]);
    return m;
  endfunction

  localparam int unsigned CW = $clog2(max_layer_size());
  localparam int unsigned LW = $clog2(NUM_LAYERS + 1);

  logic [SIZE_W-1:0] size_tab [NUM_LAYERS+1];
  for (genvar gi = 0; gi <= NUM_LAYERS; gi++) begin : g_size
    assign size_tab[gi] = LAYER_SIZES[gi*SIZE_W +: SIZE_W];
  end

  state_e                state_q;
  logic [LW-1:0]         layer_q;
  logic [CW-1:0]         neuron_q, widx_q;
  logic [31:0]           layer_num_q, neuron_num_q, words_q;
  logic [DATA_WIDTH-1:0] wval_q, bval_q;
  logic                  wvld_q, bvld_q, busy_q, done_q;

  logic              load_st, hs, last_w, last_n, last_l;
  logic [SIZE_W-1:0] size_prev, size_cur;

`ifdef CFG_CHECKSUM_EN
  assign load_st = (state_q == ST_LOAD_W) || (state_q == ST_LOAD_B) || (state_q == ST_CHECK);
`else
  assign load_st = (state_q == ST_LOAD_W) || (state_q == ST_LOAD_B);
`endif
  // abort masks ready so an aborted cycle never completes a handshake
  assign cfg_ready = load_st && !abort;
  assign hs        = cfg_valid && cfg_ready;

  assign size_prev = size_tab[layer_q - LW'(1)];
  assign size_cur  = size_tab[layer_q];
  assign last_w    = SIZE_W'(widx_q)   == (size_prev - SIZE_W'(1));
  assign last_n    = SIZE_W'(neuron_q) == (size_cur - SIZE_W'(1));
  assign last_l    = layer_q == LW'(NUM_LAYERS);

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q      <= ST_IDLE;
      layer_q      <= '0;
      neuron_q     <= '0;
      widx_q       <= '0;
      layer_num_q  <= '0;
      neuron_num_q <= '0;
      words_q      <= '0;
      wval_q       <= '0;
      bval_q       <= '0;
      wvld_q       <= 1'b0;
      bvld_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      wvld_q <= 1'b0;
      bvld_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (start) begin
          state_q  <= ST_LOAD_W;
          busy_q   <= 1'b1;
          words_q  <= '0;
          layer_q  <= LW'(1);
          neuron_q <= '0;
          widx_q   <= '0;
        end
        ST_LOAD_W: if (abort) begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end else if (hs) begin
          wval_q       <= cfg_data;
          wvld_q       <= 1'b1;
          layer_num_q  <= 32'(layer_q);
          neuron_num_q <= 32'(neuron_q);
          words_q      <= words_q + 32'd1;
          if (last_w) begin
            widx_q  <= '0;
            state_q <= ST_LOAD_B;
          end else begin
            widx_q <= widx_q + CW'(1);
          end
        end
        ST_LOAD_B: if (abort) begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end else if (hs) begin
          bval_q       <= cfg_data;
          bvld_q       <= 1'b1;
          layer_num_q  <= 32'(layer_q);
          neuron_num_q <= 32'(neuron_q);
          words_q      <= words_q + 32'd1;
          if (!last_n) begin
            neuron_q <= neuron_q + CW'(1);
            state_q  <= ST_LOAD_W;
          end else if (!last_l) begin
            neuron_q <= '0;
            layer_q  <= layer_q + LW'(1);
            state_q  <= ST_LOAD_W;
          end else begin
            neuron_q <= '0;
`ifdef CFG_CHECKSUM_EN
            state_q  <= ST_CHECK;
`else
            state_q  <= ST_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
`endif
          end
        end
`ifdef CFG_CHECKSUM_EN
        ST_CHECK: if (abort) begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end else if (hs) begin
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
`endif
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef CFG_CHECKSUM_EN
  nn_cfg_cksum u_cksum (
    .clk_i   (s_axi_aclk),
    .rst_ni  (s_axi_aresetn),
    .clear_i ((state_q == ST_IDLE) && start),
    .acc_i   (hs && (state_q != ST_CHECK)),
    .check_i (hs && (state_q == ST_CHECK)),
    .data_i  (32'(cfg_data)),
    .err_o   (cksum_err)
  );
`endif

  assign config_layer_num  = layer_num_q;
  assign config_neuron_num = neuron_num_q;
  assign weightValue       = wval_q;
  assign weightValid       = wvld_q;
  assign biasValue         = bval_q;
  assign biasValid         = bvld_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign words_loaded      = words_q;

endmodule
